// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART defaults and receiver state encoding
package uart_rx_pkg;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_OVERSAMPLE = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer resetting to 1 (idle-high line)
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk) ff_q <= rst ? 2'b11 : {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver on a 16x oversample enable
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SAMPLE_PT = OVERSAMPLE / 2
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 ferr,
  output logic                 overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_SMP = CW'(SAMPLE_PT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic armed_q, armed_d, rdy_q, rdy_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic rx_s, done;
  uart_rx_sync u_sync (.clk(clk_50m), .rst(rst), .d_i(rx), .q_o(rx_s));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    armed_d = armed_q;
    done = 1'b0;
    ferr_d = 1'b0;
    if (rxclk_en) begin
      cnt_d = cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rx_s) armed_d = 1'b1;
          else if (armed_q) state_d = START;
        end
        START: if (cnt_q == CNT_SMP) begin
          state_d = rx_s ? IDLE : DATA;
          cnt_d = '0;
          bit_d = '0;
        end
        DATA: if (cnt_q == CNT_LAST) begin
          sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + BW'(1);
          if (bit_q == BIT_LAST) state_d = STOP;
        end
        STOP: if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          done = rx_s;
          ferr_d = ~rx_s;
          armed_d = armed_q & rx_s;
        end
        default: state_d = IDLE;
      endcase
    end
    // a completing byte beats a same-cycle acknowledge
    data_d = done ? sh_q : data_q;
    rdy_d = done | (rdy_q & ~rdy_clr);
    ovr_d = ~rdy_clr & (ovr_q | (done & rdy_q));
  end
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      armed_q <= 1'b0;
      rdy_q <= 1'b0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      armed_q <= armed_d;
      rdy_q <= rdy_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
    end
  end
  assign data = data_q;
  assign rdy = rdy_q;
  assign ferr = ferr_q;
  assign overrun = ovr_q;
endmodule
